// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: reset/exception vectors,
// cause codes, FSM state encoding and redirect priority ranks.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;
    localparam logic [31:0] INT_PROC_ENTRY = 32'h8000_0200;
    localparam logic [31:0] EXC_PROC_ENTRY = 32'h8000_0180;
    localparam logic [31:0] BAD_TARGET     = 32'hFFFF_FFFF;

    localparam logic [4:0] CAUSE_INT  = 5'd0;
    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_ADES = 5'd5;
    localparam logic [4:0] CAUSE_SYS  = 5'd8;
    localparam logic [4:0] CAUSE_BP   = 5'd9;
    localparam logic [4:0] CAUSE_RI   = 5'd10;
    localparam logic [4:0] CAUSE_OV   = 5'd12;
    localparam logic [4:0] CAUSE_TRAP = 5'd13;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    // Higher value wins; a pending redirect is only replaced by a strictly higher rank.
    typedef enum logic [1:0] {
        PRI_NONE   = 2'd0,
        PRI_BRANCH = 2'd1,
        PRI_ERET   = 2'd2,
        PRI_EXC    = 2'd3
    } redir_pri_t;

    function automatic logic cause_to_exc_entry(input logic [4:0] cause);
        return (cause == CAUSE_ADEL) || (cause == CAUSE_ADES) || (cause == CAUSE_SYS) ||
               (cause == CAUSE_BP)   || (cause == CAUSE_RI)   || (cause == CAUSE_OV)  ||
               (cause == CAUSE_TRAP);
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC selection: redirect priority and exception cause decode.
module pc_target_sel
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        answer_exc,
    input  logic [4:0]  exc_cause,
    input  logic        is_eret,
    input  logic [31:0] epc,
    input  logic        is_branch,
    input  logic [31:0] branch_dst,
    output logic [31:0] target,
    output logic [1:0]  pri,
    output logic        bad_cause
);

    always_comb begin
        target    = pc + 32'd4;
        pri       = PRI_NONE;
        bad_cause = 1'b0;
        if (answer_exc) begin
            pri = PRI_EXC;
            if (exc_cause == CAUSE_INT) begin
                target = INT_PROC_ENTRY;
            end else if (cause_to_exc_entry(exc_cause)) begin
                target = EXC_PROC_ENTRY;
            end else begin
                target    = BAD_TARGET;
                bad_cause = 1'b1;
            end
        end else if (is_eret) begin
            pri    = PRI_ERET;
            target = epc;
        end else if (is_branch) begin
            pri    = PRI_BRANCH;
            target = branch_dst;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer (IDLE/FETCH/REDIRECT).
// Build option: DELAY_SLOT_EN keeps the IF instruction on a taken branch.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic        i_ID_is_branch_jump_instr,
    input  logic [31:0] i_ID_branch_jump_dst_pc,
    input  logic        i_MEM_is_eret,
    input  logic [31:0] i_MEM_epc_value,
    input  logic        i_answer_exc,
    input  logic [4:0]  i_MEM_exception_cause,
    output logic [31:0] o_IF_pc,
    output logic        o_IF_valid,
    output logic        o_flush_IF_ID,
    output logic        o_flush_ID_EX,
    output logic        o_flush_EX_MEM,
    output logic        o_bad_cause
);

    logic [1:0]  state;
    logic [31:0] pend_pc;
    logic [1:0]  pend_pri;

    logic [31:0] sel_target;
    logic [1:0]  sel_pri;
    logic        sel_bad;
    logic        active, in_fetch, accept, hard, done, br_kill;
    logic [31:0] dest;

    pc_target_sel u_target_sel (
        .pc         (o_IF_pc),
        .answer_exc (i_answer_exc),
        .exc_cause  (i_MEM_exception_cause),
        .is_eret    (i_MEM_is_eret),
        .epc        (i_MEM_epc_value),
        .is_branch  (i_ID_is_branch_jump_instr && !i_stall),
        .branch_dst (i_ID_branch_jump_dst_pc),
        .target     (sel_target),
        .pri        (sel_pri),
        .bad_cause  (sel_bad)
    );

    assign active   = (state != ST_IDLE);
    assign in_fetch = (state == ST_FETCH);
    // In REDIRECT only a strictly higher-ranked redirect replaces the pending one.
    assign accept   = active && (sel_pri != PRI_NONE) && (in_fetch || (sel_pri > pend_pri));
    assign hard     = accept && (sel_pri >= PRI_ERET);
    // Exception/ERET complete the fetch even under stall.
    assign done     = i_imem_ack && (!i_stall || hard);
    assign dest     = (accept || in_fetch) ? sel_target : pend_pc;

`ifdef DELAY_SLOT_EN
    assign br_kill = 1'b0;
`else
    assign br_kill = accept && (sel_pri == PRI_BRANCH);
`endif

    assign o_imem_req     = active;
    assign o_imem_addr    = o_IF_pc;
    assign o_IF_valid     = in_fetch && i_imem_ack && !i_stall && !hard && !br_kill;
    assign o_flush_IF_ID  = hard || br_kill;
    assign o_flush_ID_EX  = hard;
    assign o_flush_EX_MEM = hard;
    assign o_bad_cause    = hard && sel_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            o_IF_pc  <= RESET_PC;
            pend_pc  <= 32'd0;
            pend_pri <= PRI_NONE;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (done) begin
                        o_IF_pc <= dest;
                    end else if (accept) begin
                        pend_pc  <= sel_target;
                        pend_pri <= sel_pri;
                        state    <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    // The data returned here belongs to the old address and is dropped.
                    if (done) begin
                        o_IF_pc  <= dest;
                        pend_pri <= PRI_NONE;
                        state    <= ST_FETCH;
                    end else if (accept) begin
                        pend_pc  <= sel_target;
                        pend_pri <= sel_pri;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset corner case, and a
// randomized run against a behavioural fetch model.
module tb_pc_sequencer;

    localparam logic [31:0] B     = 32'hBFC0_0000;
    localparam logic [31:0] BR_T  = 32'h0040_0100;
    localparam logic [31:0] T3    = 32'h0040_0300;
    localparam logic [31:0] EPC   = 32'h8000_1000;
    localparam logic [31:0] EXC_E = 32'h8000_0180;
    localparam logic [31:0] INT_E = 32'h8000_0200;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        i_clk, i_rst_n, i_stall, i_imem_ack;
    logic        i_ID_is_branch_jump_instr, i_MEM_is_eret, i_answer_exc;
    logic [31:0] i_ID_branch_jump_dst_pc, i_MEM_epc_value;
    logic [4:0]  i_MEM_exception_cause;
    logic        o_imem_req, o_IF_valid, o_flush_IF_ID, o_flush_ID_EX, o_flush_EX_MEM, o_bad_cause;
    logic [31:0] o_imem_addr, o_IF_pc;

    pc_sequencer dut (
        .i_clk                     (i_clk),
        .i_rst_n                   (i_rst_n),
        .i_stall                   (i_stall),
        .o_imem_req                (o_imem_req),
        .o_imem_addr               (o_imem_addr),
        .i_imem_ack                (i_imem_ack),
        .i_ID_is_branch_jump_instr (i_ID_is_branch_jump_instr),
        .i_ID_branch_jump_dst_pc   (i_ID_branch_jump_dst_pc),
        .i_MEM_is_eret             (i_MEM_is_eret),
        .i_MEM_epc_value           (i_MEM_epc_value),
        .i_answer_exc              (i_answer_exc),
        .i_MEM_exception_cause     (i_MEM_exception_cause),
        .o_IF_pc                   (o_IF_pc),
        .o_IF_valid                (o_IF_valid),
        .o_flush_IF_ID             (o_flush_IF_ID),
        .o_flush_ID_EX             (o_flush_ID_EX),
        .o_flush_EX_MEM            (o_flush_EX_MEM),
        .o_bad_cause               (o_bad_cause)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          stall, ack, br, eret, exc;
        logic [31:0] br_dst, epc;
        logic [4:0]  cause;
        bit          req;
        logic [31:0] addr;
        bit          valid, fl_if, fl_late, bad;
    } vec_t;

    function automatic vec_t mk(bit stall, bit ack, bit br, logic [31:0] br_dst, bit eret,
                                bit exc, logic [4:0] cause, bit req, logic [31:0] addr,
                                bit valid, bit fl_if, bit fl_late, bit bad);
        vec_t v;
        v.stall = stall; v.ack = ack; v.br = br; v.br_dst = br_dst; v.eret = eret;
        v.epc = EPC; v.exc = exc; v.cause = cause; v.req = req; v.addr = addr;
        v.valid = valid; v.fl_if = fl_if; v.fl_late = fl_late; v.bad = bad;
        return v;
    endfunction

    task automatic drive(bit stall, bit ack, bit br, logic [31:0] br_dst, bit eret,
                         logic [31:0] epc, bit exc, logic [4:0] cause);
        i_stall = stall; i_imem_ack = ack; i_ID_is_branch_jump_instr = br;
        i_ID_branch_jump_dst_pc = br_dst; i_MEM_is_eret = eret; i_MEM_epc_value = epc;
        i_answer_exc = exc; i_MEM_exception_cause = cause;
    endtask

    // Behavioural model: mode 0 = waiting out reset, 1 = fetching, 2 = fetch in flight with redirect owed.
    int          m_mode, m_rank;
    logic [31:0] m_pc, m_pend;

    function automatic logic [31:0] exc_vector(input logic [4:0] cause, output bit bad);
        int ok[7] = '{4, 5, 8, 9, 10, 12, 13};
        bad = 1'b0;
        if (cause == 5'd0) return INT_E;
        foreach (ok[k]) if (int'(cause) == ok[k]) return EXC_E;
        bad = 1'b1;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_cycle();
        int          rank;
        bit          bad, take, hardx, kill, fin;
        logic [31:0] tgt;
        logic [38:0] exp_v, act_v;
        bad  = 1'b0;
        rank = i_answer_exc ? 3 : i_MEM_is_eret ? 2 : (i_ID_is_branch_jump_instr && !i_stall) ? 1 : 0;
        case (rank)
            3:       tgt = exc_vector(i_MEM_exception_cause, bad);
            2:       tgt = i_MEM_epc_value;
            1:       tgt = i_ID_branch_jump_dst_pc;
            default: tgt = m_pc + 32'd4;
        endcase
        take  = (m_mode != 0) && (rank > 0) && (m_mode == 1 || rank > m_rank);
        hardx = take && rank >= 2;
        kill  = !DS && take && rank == 1;
        exp_v = {m_mode != 0, m_pc,
                 (m_mode == 1) && i_imem_ack && !i_stall && !hardx && !kill,
                 hardx || kill, hardx, hardx, hardx && rank == 3 && bad};
        act_v = {o_imem_req, o_imem_addr, o_IF_valid, o_flush_IF_ID, o_flush_ID_EX,
                 o_flush_EX_MEM, o_bad_cause};
        check("random", 64'(act_v), 64'(exp_v));
        fin = i_imem_ack && (!i_stall || hardx);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (fin) begin
            m_pc   = take ? tgt : (m_mode == 2 ? m_pend : m_pc + 32'd4);
            m_mode = 1;
            m_rank = 0;
        end else if (take) begin
            m_pend = tgt;
            m_rank = rank;
            m_mode = 2;
        end
    endtask

    vec_t vecs[28];

    initial begin
        vecs[0]  = mk(0,1,0,0,   0,0,0,  0,B,        0,0,0,0);
        vecs[1]  = mk(0,1,0,0,   0,0,0,  1,B,        1,0,0,0);
        vecs[2]  = mk(0,1,0,0,   0,0,0,  1,B+4,      1,0,0,0);
        vecs[3]  = mk(0,1,0,0,   0,0,0,  1,B+8,      1,0,0,0);
        vecs[4]  = mk(0,1,1,BR_T,0,0,0,  1,B+12,     DS,!DS,0,0);
        vecs[5]  = mk(0,1,0,0,   0,0,0,  1,BR_T,     1,0,0,0);
        vecs[6]  = mk(0,0,1,BR_T,0,0,0,  1,BR_T+4,   0,!DS,0,0);
        vecs[7]  = mk(0,0,0,0,   0,0,0,  1,BR_T+4,   0,0,0,0);
        vecs[8]  = mk(0,0,0,0,   0,0,0,  1,BR_T+4,   0,0,0,0);
        vecs[9]  = mk(0,1,0,0,   0,0,0,  1,BR_T+4,   0,0,0,0);
        vecs[10] = mk(0,1,0,0,   0,0,0,  1,BR_T,     1,0,0,0);
        vecs[11] = mk(1,1,0,0,   0,0,0,  1,BR_T+4,   0,0,0,0);
        vecs[12] = mk(1,1,1,T3,  0,0,0,  1,BR_T+4,   0,0,0,0);
        vecs[13] = mk(0,1,0,0,   0,0,0,  1,BR_T+4,   1,0,0,0);
        vecs[14] = mk(0,0,1,T3,  0,0,0,  1,BR_T+8,   0,!DS,0,0);
        vecs[15] = mk(0,0,0,0,   0,1,12, 1,BR_T+8,   0,1,1,0);
        vecs[16] = mk(0,0,0,0,   0,1,12, 1,BR_T+8,   0,0,0,0);
        vecs[17] = mk(0,0,0,0,   1,0,0,  1,BR_T+8,   0,0,0,0);
        vecs[18] = mk(0,1,0,0,   0,0,0,  1,BR_T+8,   0,0,0,0);
        vecs[19] = mk(0,1,0,0,   0,1,31, 1,EXC_E,    0,1,1,1);
        vecs[20] = mk(0,1,0,0,   0,0,0,  1,32'hFFFF_FFFF, 1,0,0,0);
        vecs[21] = mk(1,1,0,0,   1,0,0,  1,32'h3,    0,1,1,0);
        vecs[22] = mk(0,1,1,T3,  1,1,0,  1,EPC,      0,1,1,0);
        vecs[23] = mk(0,1,0,0,   0,0,0,  1,INT_E,    1,0,0,0);
        vecs[24] = mk(1,0,0,0,   0,1,8,  1,INT_E+4,  0,1,1,0);
        vecs[25] = mk(1,1,0,0,   0,0,0,  1,INT_E+4,  0,0,0,0);
        vecs[26] = mk(0,1,0,0,   0,0,0,  1,INT_E+4,  0,0,0,0);
        vecs[27] = mk(0,0,0,0,   0,0,0,  1,EXC_E,    0,0,0,0);

        drive(0,0,0,0,0,0,0,0);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #2;
        check("reset_pc", 64'(o_IF_pc), 64'(B));
        check("reset_outs", 64'({o_imem_req, o_IF_valid, o_flush_IF_ID, o_flush_ID_EX, o_flush_EX_MEM, o_bad_cause}), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        foreach (vecs[n]) begin
            drive(vecs[n].stall, vecs[n].ack, vecs[n].br, vecs[n].br_dst, vecs[n].eret,
                  vecs[n].epc, vecs[n].exc, vecs[n].cause);
            #2;
            check($sformatf("v%0d_req", n),   64'(o_imem_req),    64'(vecs[n].req));
            check($sformatf("v%0d_addr", n),  64'(o_imem_addr),   64'(vecs[n].addr));
            check($sformatf("v%0d_valid", n), 64'(o_IF_valid),    64'(vecs[n].valid));
            check($sformatf("v%0d_flif", n),  64'(o_flush_IF_ID), 64'(vecs[n].fl_if));
            check($sformatf("v%0d_fllate", n), 64'({o_flush_ID_EX, o_flush_EX_MEM}),
                  64'({vecs[n].fl_late, vecs[n].fl_late}));
            check($sformatf("v%0d_bad", n),   64'(o_bad_cause),   64'(vecs[n].bad));
            @(negedge i_clk);
        end

        // Reset asserted while a redirect is pending; ack during reset must be ignored.
        drive(0,0,1,BR_T,0,0,0,0);
        @(negedge i_clk);
        drive(0,0,0,0,0,0,0,0);
        #1 i_rst_n = 1'b0;
        #1;
        check("rst_mid_pc", 64'(o_IF_pc), 64'(B));
        check("rst_mid_req", 64'(o_imem_req), 64'd0);
        i_imem_ack = 1'b1;
        #1;
        check("rst_ack_valid", 64'(o_IF_valid), 64'd0);
        @(negedge i_clk);
        check("rst_hold_pc", 64'(o_IF_pc), 64'(B));
        i_rst_n = 1'b1;
        #2;
        check("idle_req", 64'(o_imem_req), 64'd0);
        check("idle_valid", 64'(o_IF_valid), 64'd0);
        @(negedge i_clk);
        #2;
        check("first_fetch", 64'({o_imem_req, o_imem_addr, o_IF_valid}), 64'({1'b1, B, 1'b1}));

        // Randomized run from a fresh reset against the model.
        @(negedge i_clk);
        drive(0,0,0,0,0,0,0,0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_mode = 0; m_rank = 0; m_pc = B; m_pend = 32'd0;
        for (int c = 0; c < 500; c++) begin
            begin
                logic [4:0] cz;
                case ($urandom_range(0, 3))
                    0:       cz = 5'd0;
                    1:       cz = 5'd12;
                    2:       cz = 5'(4 + $urandom_range(0, 9));
                    default: cz = 5'($urandom_range(0, 31));
                endcase
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 7) == 0,
                      $urandom, $urandom_range(0, 9) == 0, cz);
            end
            #2;
            model_cycle();
            @(negedge i_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
